// File: rtl/video_oam_dma.sv
// rtl/video_oam_dma.sv - 256-byte sprite-attribute DMA engine with CPU halt and get/put alignment
//
// Copies the 256 bytes of host page {I_page,00..FF} into OAM, one byte per
// get/put CPU-cycle pair, while holding the CPU halted.
//
// Ports:
//   I_clock     system clock, rising edge
//   I_reset     asynchronous active-low reset
//   I_tick      one-clock pulse at the start of each CPU cycle
//   I_start     one-clock pulse: begin a transfer from page I_page
//   I_page      source page, latched on an accepted I_start
//   O_halt      CPU halt request, high whenever not idle
//   O_bus_addr  host read address {page,idx}
//   O_bus_rden  host read enable, high while in READ
//   I_bus_data  host read data, captured at the end of READ
//   O_oam_wren  OAM data write strobe (first clock of WRITE)
//   O_oam_inc   OAM address increment strobe (second clock of WRITE)
//   O_oam_data  byte being written into OAM
//   O_done      one-clock pulse when the last byte has been written
module video_oam_dma (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_tick,
    input  logic        I_start,
    input  logic [7:0]  I_page,
    output logic        O_halt,
    output logic [15:0] O_bus_addr,
    output logic        O_bus_rden,
    input  logic [7:0]  I_bus_data,
    output logic        O_oam_wren,
    output logic        O_oam_inc,
    output logic [7:0]  O_oam_data,
    output logic        O_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        parity_q, parity_d;
    // Set once HALT has seen the tick that opens a full halted CPU cycle.
    logic        full_q, full_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic        halt_q, halt_d;
    logic [15:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        wren_q, wren_d;
    logic        inc_q, inc_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;

    always_comb begin
        state_d  = state_q;
        parity_d = parity_q ^ I_tick;
        full_d   = full_q;
        page_d   = page_q;
        idx_d    = idx_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        // The increment strobe always trails the write strobe by one clock.
        inc_d    = wren_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (I_start) begin
                    page_d  = I_page;
                    idx_d   = 8'd0;
                    // A tick arriving with the start already opens the full halt cycle.
                    full_d  = I_tick;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (I_tick) begin
                    if (!full_q) begin
                        full_d = 1'b1;
                    end else begin
                        // Reads must land in get cycles (new parity 0).
                        state_d = parity_d ? S_ALIGN : S_READ;
                    end
                end
            end
            S_ALIGN: begin
                if (I_tick) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (I_tick) begin
                    data_d  = I_bus_data;
                    wren_d  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (I_tick) begin
                    if (idx_q == 8'hFF) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        halt_d = (state_d != S_IDLE);
        rden_d = (state_d == S_READ);
        addr_d = {page_d, idx_d};
    end

    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state_q  <= S_IDLE;
            parity_q <= 1'b0;
            full_q   <= 1'b0;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            halt_q   <= 1'b0;
            addr_q   <= 16'd0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            inc_q    <= 1'b0;
            data_q   <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            parity_q <= parity_d;
            full_q   <= full_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            halt_q   <= halt_d;
            addr_q   <= addr_d;
            rden_q   <= rden_d;
            wren_q   <= wren_d;
            inc_q    <= inc_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign O_halt     = halt_q;
    assign O_bus_addr = addr_q;
    assign O_bus_rden = rden_q;
    assign O_oam_wren = wren_q;
    assign O_oam_inc  = inc_q;
    assign O_oam_data = data_q;
    assign O_done     = done_q;

endmodule

// File: tb/tb_video_oam_dma.sv
// tb/tb_video_oam_dma.sv - self-checking bench for video_oam_dma
module tb_video_oam_dma;

    logic        I_clock;
    logic        I_reset;
    logic        I_tick;
    logic        I_start;
    logic [7:0]  I_page;
    logic        O_halt;
    logic [15:0] O_bus_addr;
    logic        O_bus_rden;
    logic [7:0]  I_bus_data;
    logic        O_oam_wren;
    logic        O_oam_inc;
    logic [7:0]  O_oam_data;
    logic        O_done;

    logic [7:0]  mem_tab [256];

    video_oam_dma dut (
        .I_clock    (I_clock),
        .I_reset    (I_reset),
        .I_tick     (I_tick),
        .I_start    (I_start),
        .I_page     (I_page),
        .O_halt     (O_halt),
        .O_bus_addr (O_bus_addr),
        .O_bus_rden (O_bus_rden),
        .I_bus_data (I_bus_data),
        .O_oam_wren (O_oam_wren),
        .O_oam_inc  (O_oam_inc),
        .O_oam_data (O_oam_data),
        .O_done     (O_done)
    );

    assign I_bus_data = mem_tab[O_bus_addr[7:0]];

    initial begin
        I_clock = 1'b0;
        forever #5 I_clock = ~I_clock;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: parity of ticks seen since reset, tick spacing, page under copy.
    logic       mparity  = 1'b0;
    int         tick_cnt = 0;
    bit         rand_mode = 0;
    logic [7:0] xpage = 8'd0;

    // Per-transfer observations, cleared by the monitor when O_halt rises.
    int halt_ticks = 0;
    int wr_i = 0, inc_i = 0, rd_i = 0, done_i = 0;
    int bad_addr = 0, bad_data = 0, inc_bad = 0, rdpar_bad = 0;
    logic prev_halt = 1'b0, prev_wren = 1'b0, prev_rden = 1'b0;
    logic tick_at_edge;

    always @(posedge I_clock) begin
        tick_at_edge = I_tick;
        #1;
        if (O_halt === 1'b1 && prev_halt !== 1'b1) begin
            halt_ticks = 0; wr_i = 0; inc_i = 0; rd_i = 0; done_i = 0;
            bad_addr = 0; bad_data = 0; inc_bad = 0; rdpar_bad = 0;
        end
        if (tick_at_edge && O_halt === 1'b1) halt_ticks++;
        if (O_bus_rden === 1'b1 && prev_rden !== 1'b1) begin
            if (mparity !== 1'b0) rdpar_bad++;
            if (O_bus_addr !== {xpage, 8'(rd_i)}) bad_addr++;
            rd_i++;
        end
        if (O_oam_wren === 1'b1) begin
            if (wr_i < 256) begin
                if (O_bus_addr !== {xpage, 8'(wr_i)}) bad_addr++;
                if (O_oam_data !== mem_tab[wr_i[7:0]]) bad_data++;
            end
            wr_i++;
        end
        if (O_oam_inc === 1'b1) begin
            inc_i++;
            if (prev_wren !== 1'b1) inc_bad++;
        end
        if (O_done === 1'b1) done_i++;
        prev_halt = O_halt;
        prev_wren = O_oam_wren;
        prev_rden = O_bus_rden;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // One clock of stimulus, applied from a falling edge.
    task automatic step(input logic st, input logic [7:0] pg);
        logic t;
        t = (tick_cnt == 0);
        I_tick  = t;
        I_start = st;
        I_page  = pg;
        if (t) begin
            mparity  = I_reset ? ~mparity : 1'b0;
            tick_cnt = rand_mode ? int'($urandom_range(5, 2)) : 3;
        end else begin
            tick_cnt--;
        end
        @(negedge I_clock);
        I_tick  = 1'b0;
        I_start = 1'b0;
    endtask

    task automatic align_to(input string nm, input bit coinc, input logic want_p);
        int n;
        n = 0;
        while (!(((coinc && tick_cnt == 0) || (!coinc && tick_cnt != 0)) && mparity == want_p)
               && n < 100) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk({nm, "_arrange"}, (n < 100), 1);
    endtask

    task automatic run_xfer(input string nm, input logic [7:0] pg, input bit coinc,
                            input logic want_p, input int exp_ticks, input bit inject);
        int  n;
        bit  injected;
        align_to(nm, coinc, want_p);
        xpage = pg;
        step(1'b1, pg);
        n = 0;
        injected = 0;
        while (done_i == 0 && n < 5000) begin
            if (inject && !injected && wr_i == 50 && tick_cnt != 0) begin
                step(1'b1, 8'h07);
                injected = 1;
            end else begin
                step(1'b0, 8'h00);
            end
            n++;
        end
        repeat (4) step(1'b0, 8'h00);
        chk({nm, "_done"},       done_i, 1);
        chk({nm, "_halt_ticks"}, halt_ticks, exp_ticks);
        chk({nm, "_wren"},       wr_i, 256);
        chk({nm, "_inc"},        inc_i, 256);
        chk({nm, "_reads"},      rd_i, 256);
        chk({nm, "_bad_addr"},   bad_addr, 0);
        chk({nm, "_bad_data"},   bad_data, 0);
        chk({nm, "_inc_order"},  inc_bad, 0);
        chk({nm, "_read_get"},   rdpar_bad, 0);
        chk({nm, "_halt_end"},   O_halt, 0);
    endtask

    typedef struct {
        string      name;
        logic [7:0] page;
        bit         coinc;
        logic       odd;
        bit         inject;
        int         exp_ticks;
    } vec_t;

    vec_t vecs [5];
    int   stray;

    initial begin
        #1_500_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"even_p02",   8'h02, 1'b0, 1'b0, 1'b0, 513};
        vecs[1] = '{"odd_p02",    8'h02, 1'b0, 1'b1, 1'b0, 514};
        vecs[2] = '{"inject_p03", 8'h03, 1'b0, 1'b0, 1'b1, 513};
        vecs[3] = '{"coinc_even", 8'hFF, 1'b1, 1'b0, 1'b0, 513};
        vecs[4] = '{"coinc_odd",  8'h00, 1'b1, 1'b1, 1'b0, 514};
        for (int i = 0; i < 256; i++) mem_tab[i] = 8'(i) ^ 8'h5A;

        I_tick = 1'b0; I_start = 1'b0; I_page = 8'h00;
        I_reset = 1'b1;
        #1 I_reset = 1'b0;
        @(negedge I_clock);
        repeat (3) step(1'b0, 8'h00);
        chk("rst_halt", O_halt, 0);
        chk("rst_addr", O_bus_addr, 0);
        chk("rst_rden", O_bus_rden, 0);
        chk("rst_wren", O_oam_wren, 0);
        chk("rst_inc",  O_oam_inc, 0);
        chk("rst_data", O_oam_data, 0);
        chk("rst_done", O_done, 0);
        I_reset = 1'b1;
        mparity = 1'b0;
        repeat (2) step(1'b0, 8'h00);

        for (int i = 0; i < 5; i++)
            run_xfer(vecs[i].name, vecs[i].page, vecs[i].coinc, vecs[i].odd,
                     vecs[i].exp_ticks, vecs[i].inject);

        // Reset during byte 100, then a clean restart from page 0x01.
        xpage = 8'h05;
        align_to("abort", 1'b0, 1'b0);
        step(1'b1, 8'h05);
        for (int n = 0; n < 3000 && wr_i < 100; n++) step(1'b0, 8'h00);
        chk("abort_reached", wr_i, 100);
        #3 I_reset = 1'b0;
        mparity = 1'b0;
        #1;
        chk("abort_halt", O_halt, 0);
        chk("abort_wren", O_oam_wren, 0);
        chk("abort_inc",  O_oam_inc, 0);
        chk("abort_rden", O_bus_rden, 0);
        chk("abort_done", O_done, 0);
        @(negedge I_clock);
        stray = 0;
        for (int n = 0; n < 8; n++) begin
            step(1'b0, 8'h00);
            if (O_halt || O_oam_wren || O_oam_inc || O_done || O_bus_rden) stray++;
        end
        chk("abort_quiet", stray, 0);
        I_reset = 1'b1;
        mparity = 1'b0;
        step(1'b0, 8'h00);
        run_xfer("restart_p01", 8'h01, 1'b0, 1'b0, 513, 1'b0);

        // Random tick spacing, memory contents, page, phase and start alignment.
        rand_mode = 1;
        for (int t = 0; t < 3; t++) begin
            logic [7:0] pg;
            bit         cc;
            logic       pp;
            for (int i = 0; i < 256; i++) mem_tab[i] = 8'($urandom);
            pg = 8'($urandom);
            cc = 1'($urandom);
            pp = 1'($urandom);
            // Reads must start in a get cycle, so an odd phase costs one extra aligning cycle.
            run_xfer($sformatf("rand%0d", t), pg, cc, pp, 513 + int'(pp), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/video_oam_dma.md
VIDEO_OAM_DMA -- requirements
Module: video_oam_dma

Interface
REQ-001 SHALL have no parameters; the page width is fixed at 8 bits and the transfer length at 256 bytes.
REQ-002 SHALL use one clock, I_clock; reset I_reset is asynchronous and active-low.
REQ-003 Port I_clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port I_reset  input  1  asynchronous active-low reset.
REQ-005 Port I_tick  input  1  one-clock pulse marking the start of each CPU cycle.
REQ-006 Port I_start  input  1  one-clock pulse from a host write to the DMA page register.
REQ-007 Port I_page  input  8  source page; sampled when I_start is accepted.
REQ-008 Port O_halt  output  1  CPU halt request.
REQ-009 Port O_bus_addr  output  16  host bus read address.
REQ-010 Port O_bus_rden  output  1  host bus read enable.
REQ-011 Port I_bus_data  input  8  host bus read data.
REQ-012 Port O_oam_wren  output  1  OAM data write strobe; connects to the OAM data write input.
REQ-013 Port O_oam_inc  output  1  OAM address increment strobe.
REQ-014 Port O_oam_data  output  8  byte to write into OAM.
REQ-015 Port O_done  output  1  one-clock pulse at transfer end.

Function
REQ-016 SHALL implement the states IDLE, HALT, ALIGN, READ and WRITE; all outputs SHALL be registered.
REQ-017 Parity flop P: toggles on every I_tick in every state; the CPU cycle starting at a tick is "get" if the new P=0 and "put" if the new P=1.
REQ-018 IDLE: I_start=1 -> latch page, idx<=0, go to HALT on the same edge.
REQ-019 HALT: on I_tick -> READ if the new P=0, else ALIGN; HALT SHALL always span at least one full CPU cycle.
REQ-020 ALIGN: on I_tick -> READ.
REQ-021 READ: O_bus_rden=1 and O_bus_addr={page,idx} for the whole state; on I_tick -> capture I_bus_data into O_oam_data and go to WRITE.
REQ-022 WRITE, first clock in the state: O_oam_wren=1 for exactly one clock.
REQ-023 WRITE, second clock in the state: O_oam_inc=1 for exactly one clock.
REQ-024 WRITE, on I_tick: if idx=255 -> go to IDLE with O_done=1 for one clock; else idx<=idx+1 and go to READ.
REQ-025 SHALL assert O_halt in every state except IDLE and deassert it on the edge entering IDLE.
REQ-026 Transfer length SHALL be 1 halt + 0/1 align + 512 CPU cycles, i.e. 513 or 514 ticks.
REQ-027 SHALL keep O_bus_addr = {page,idx} in all states; O_bus_rden=0 outside READ.
REQ-028 idx SHALL be 8 bits; it never wraps inside a transfer, and termination is decided by idx=255 only.
REQ-029 I_start while not IDLE SHALL be ignored; the page is not relatched.
REQ-030 I_start and I_tick in the same clock: enter HALT, toggle P, and not count that tick toward HALT.
REQ-031 SHALL never clear or write the OAM address; the copy starts at the current OAM address and wraps there naturally.
REQ-032 Requires ticks spaced at least 3 clocks apart; behaviour for closer ticks is not specified.

Reset
REQ-033 I_reset low SHALL asynchronously force IDLE and P=0.
REQ-034 I_reset low SHALL force to 0: idx, page, O_halt, O_bus_addr, O_bus_rden, O_oam_wren, O_oam_inc, O_oam_data and O_done.
REQ-035 Reset mid-transfer SHALL abort with no further strobes; the next I_start SHALL begin a fresh 256-byte transfer.

Verification
REQ-036 Even start: ticks every 4 clocks, P=0, I_start page=0x02 -> O_halt for 513 ticks, reads 0x0200..0x02FF in order, 256 O_oam_wren and 256 O_oam_inc pulses, one O_done.
REQ-037 Odd start: P=1 at I_start -> one ALIGN cycle, 514 ticks of O_halt, first read at 0x0200 in a get cycle.
REQ-038 Data path: memory byte = low address byte XOR 0x5A -> the Nth O_oam_wren carries N XOR 0x5A for all N from 0 to 255.
REQ-039 I_start page=0x07 pulsed mid-transfer of page 0x03 -> ignored; all addresses stay 0x03xx and the count stays 256.
REQ-040 Reset asserted at byte 100 -> O_halt=0 and all strobes 0 immediately; restart with page 0x01 -> full 256-byte copy from 0x0100.
REQ-041 I_start and I_tick coincident -> HALT lasts until the following tick; the total tick count still matches REQ-026.
